id_hazard_scoreboard: RTL and testbench
=======================================

Name: id_hazard_scoreboard

Overview:
- Parametrised register/condition-code hazard tracker for the decode stage. It replaces per-stage rd comparisons with per-register in-flight counters.
- Decode presents the source operands of the instruction it holds and receives a same-cycle stall. It reports each issued producer and each retired writeback.
- Tracks integer registers (including double-word pairs), icc and Y.
- Pipeline depth, register count and writeback-bypass mode are parameters.

Parameters:
- NUM_REGS, 32, number of tracked architectural registers; r0 is never tracked.
- ADDR_W, 5, register index width; must equal clog2(NUM_REGS).
- CNT_W, 2, in-flight counter width. At most 2^CNT_W-1 pending writers per resource.
- RETIRE_BYPASS, 1. When 1, a retire in the same cycle clears a hazard whose count is 1. When 0, the hazard clears the cycle after retire.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- chk_rs1  in  ADDR_W  source 1 of the instruction in decode
- chk_rs1_en  in  1  rs1 is read
- chk_rs2  in  ADDR_W  source 2
- chk_rs2_en  in  1  rs2 is read (0 for immediate forms)
- chk_rs3  in  ADDR_W  store-data register (rd field of a store)
- chk_rs3_en  in  1  store data is read
- chk_rs3_double  in  1  store-double: rs3 and rs3+1 are both read
- chk_icc  in  1  instruction reads icc (Bicc, Ticc, ADDX/SUBX)
- chk_y  in  1  instruction reads Y (RDY, UDIV, SDIV)
- issue_valid  in  1  decode hands an instruction to EX this cycle
- issue_rd  in  ADDR_W  destination register
- issue_wr  in  1  writes rd
- issue_wr_double  in  1  writes rd and rd+1 (LDD)
- issue_icc  in  1  writes icc
- issue_y  in  1  writes Y
- retire_valid, retire_rd, retire_wr, retire_wr_double, retire_icc, retire_y  in  1/ADDR_W/1/1/1/1  same fields, presented by writeback
- flush  in  1  pipeline squash: clear all pending state
- stall  out  1  decode must hold; issue_valid must be 0 while stall is 1
- pending_mask  out  NUM_REGS  bit n set when reg n count is nonzero (registered state)
- icc_pending  out  1  icc count nonzero
- y_pending  out  1  Y count nonzero
- err  out  1  sticky protocol error

Behaviour:
- State: cnt[NUM_REGS] of CNT_W bits (cnt[0] held at 0), icc_cnt and y_cnt of CNT_W bits, and err.
- Reset (synchronous, clk edge while reset=1): all counters 0 and err 0. All outputs then read 0, except that stall follows its combinational definition.
- Issue, applied at the clk edge when issue_valid=1:
  - cnt[issue_rd] +1 when issue_wr=1 and issue_rd!=0.
  - cnt[(issue_rd+1) mod NUM_REGS] +1 when issue_wr_double=1. issue_rd must be even for doubles; if it is odd, set err and still perform the update.
  - icc_cnt +1 when issue_icc=1; y_cnt +1 when issue_y=1.
- Retire, applied at the clk edge when retire_valid=1: the same fields decrement the same counters.
- Per-counter net update: +1, -1, or 0 when issue and retire hit the same counter in the same cycle.
- Saturation and underflow:
  - An increment of a counter already at max, or a decrement of a counter at 0, leaves the counter unchanged and sets err.
  - err clears only on reset.
- flush: at the clk edge all counters go to 0. flush overrides issue and retire in the same cycle. err is unaffected.
- Reset asserted mid-operation behaves exactly like reset; in-flight pending state is discarded.
- Per-counter hazard (combinational, using the current registered counters):
  - haz(n) = cnt[n] != 0.
  - With RETIRE_BYPASS=1, additionally require NOT (cnt[n]==1 and a retire this cycle targets n).
  - icc and Y follow the same rule.
- stall = OR of the following, each gated by its enable:
  - haz(chk_rs1) if chk_rs1_en=1 and chk_rs1!=0
  - haz(chk_rs2) if chk_rs2_en=1 and chk_rs2!=0
  - haz(chk_rs3) if chk_rs3_en=1
  - haz(chk_rs3+1) if chk_rs3_double=1
  - icc hazard if chk_icc=1; Y hazard if chk_y=1
  - any counter that a would-be issue of the same instruction would increment is at max (structural stall; gated by issue_wr/issue_wr_double/issue_icc/issue_y, independent of issue_valid)
- Latency:
  - stall has 0 cycles of latency from the chk_* inputs.
  - An issue is visible in stall and pending_mask from the next cycle.
  - A retire is visible in the same cycle (RETIRE_BYPASS=1) or the next cycle (RETIRE_BYPASS=0).
- All register index arithmetic wraps modulo NUM_REGS.

Decomposition:
- Shared package: the resource-update struct {valid, rd, wr, wr_double, icc, y}, used for both the issue and retire ports, and the localparam CNT_MAX.
- One natural sub-module, sb_counter: a CNT_W up/down counter with saturate/underflow flags and clear. Instantiate NUM_REGS-1+2 copies: registers 1..NUM_REGS-1, plus icc and Y.

Test Plan:
- Issue rd=5 (wr=1), next cycle chk_rs1=5 -> stall=1 and pending_mask[5]=1. Retire rd=5 with RETIRE_BYPASS=1 -> stall=0 that same cycle, pending_mask[5]=0 the next cycle. With RETIRE_BYPASS=0, stall falls one cycle later.
- Issue LDD rd=8 (wr_double) -> pending_mask bits 8 and 9 set. chk_rs3=6 with chk_rs3_double=0 -> stall=0. chk_rs2=9 -> stall=1. Issue LDD with rd=9 -> err=1.
- Issue rd=3 three times with CNT_W=2 -> cnt=3. A fourth instruction with issue_rd=3 presented -> stall=1 (structural). Forcing issue_valid anyway -> cnt stays 3 and err=1.
- Same cycle: issue rd=4 and retire rd=4 with cnt[4]=1 -> cnt[4] stays 1 and pending_mask[4]=1 next cycle.
- SUBcc issued (issue_icc) then Bicc with chk_icc=1 -> stall=1 until the retire with retire_icc. chk_rs1=0 with r0 "issued" -> stall=0 and pending_mask[0]=0.
- Pend regs 1, 2, icc and Y, then flush together with a simultaneous issue of rd=7 -> next cycle all pending outputs are 0, pending_mask is all 0, and err is unchanged.

Source files
------------

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types and helpers for the decode-stage hazard scoreboard.
package id_hazard_scoreboard_pkg;

    localparam int unsigned RD_W     = 8;
    localparam int unsigned SB_CNT_W = 2;
    localparam int unsigned CNT_MAX  = (1 << SB_CNT_W) - 1;

    // One producer/retire event; rd is wide enough for any supported register file.
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            wr;
        logic            wr_double;
        logic            icc;
        logic            y;
    } res_upd_t;

    // Pair partner index, wrapping modulo the register count.
    function automatic logic [RD_W-1:0] rd_next(input logic [RD_W-1:0] rd,
                                                input int unsigned num_regs);
        return RD_W'((32'(rd) + 32'd1) % num_regs);
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_sb_counter.sv
// Saturating in-flight counter for one resource; flags overflow/underflow attempts.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             err_c
);

    localparam logic [CNT_W-1:0] CNT_TOP = '1;

    logic up_c;
    logic dn_c;

    // Simultaneous inc and dec cancel, so neither can overflow nor underflow.
    always_comb begin
        up_c  = inc && !dec && (cnt != CNT_TOP);
        dn_c  = dec && !inc && (cnt != '0);
        err_c = !clear && ((inc && !dec && (cnt == CNT_TOP)) ||
                           (dec && !inc && (cnt == '0)));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (up_c) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dn_c) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard tracker: per-register, icc and Y in-flight counters drive
// a same-cycle stall for the instruction held in decode.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS      = 32,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned CNT_W         = SB_CNT_W,
    parameter bit          RETIRE_BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   chk_rs1,
    input  logic                chk_rs1_en,
    input  logic [ADDR_W-1:0]   chk_rs2,
    input  logic                chk_rs2_en,
    input  logic [ADDR_W-1:0]   chk_rs3,
    input  logic                chk_rs3_en,
    input  logic                chk_rs3_double,
    input  logic                chk_icc,
    input  logic                chk_y,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_wr,
    input  logic                issue_wr_double,
    input  logic                issue_icc,
    input  logic                issue_y,
    input  logic                retire_valid,
    input  logic [ADDR_W-1:0]   retire_rd,
    input  logic                retire_wr,
    input  logic                retire_wr_double,
    input  logic                retire_icc,
    input  logic                retire_y,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                icc_pending,
    output logic                y_pending,
    output logic                err
);

    res_upd_t            iss_u;
    res_upd_t            ret_u;
    logic [RD_W-1:0]     iss_rd1;
    logic [RD_W-1:0]     ret_rd1;
    logic [NUM_REGS-1:1] inc;
    logic [NUM_REGS-1:1] dec;
    logic [NUM_REGS-1:1] cnt_err;
    logic [NUM_REGS-1:0] haz;
    logic [NUM_REGS-1:0] at_max;
    logic [CNT_W-1:0]    cnt [1:NUM_REGS-1];
    logic [CNT_W-1:0]    icc_cnt;
    logic [CNT_W-1:0]    y_cnt;
    logic                icc_inc;
    logic                icc_dec;
    logic                y_inc;
    logic                y_dec;
    logic                icc_err;
    logic                y_err;
    logic                icc_haz;
    logic                y_haz;
    logic                odd_err;
    logic                struct_stall;

    always_comb begin
        iss_u = '{valid: issue_valid, rd: RD_W'(issue_rd), wr: issue_wr,
                  wr_double: issue_wr_double, icc: issue_icc, y: issue_y};
        ret_u = '{valid: retire_valid, rd: RD_W'(retire_rd), wr: retire_wr,
                  wr_double: retire_wr_double, icc: retire_icc, y: retire_y};
    end

    // Decode issue/retire events into per-counter inc/dec strobes; r0 is never tracked.
    always_comb begin
        iss_rd1 = rd_next(iss_u.rd, NUM_REGS);
        ret_rd1 = rd_next(ret_u.rd, NUM_REGS);
        inc     = '0;
        dec     = '0;
        for (int unsigned n = 1; n < NUM_REGS; n++) begin
            inc[n] = iss_u.valid && ((iss_u.wr && (iss_u.rd == RD_W'(n))) ||
                                     (iss_u.wr_double && (iss_rd1 == RD_W'(n))));
            dec[n] = ret_u.valid && ((ret_u.wr && (ret_u.rd == RD_W'(n))) ||
                                     (ret_u.wr_double && (ret_rd1 == RD_W'(n))));
        end
        icc_inc = iss_u.valid && iss_u.icc;
        icc_dec = ret_u.valid && ret_u.icc;
        y_inc   = iss_u.valid && iss_u.y;
        y_dec   = ret_u.valid && ret_u.y;
        odd_err = (iss_u.valid && iss_u.wr_double && iss_u.rd[0]) ||
                  (ret_u.valid && ret_u.wr_double && ret_u.rd[0]);
    end

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (flush),
            .inc   (inc[g]),
            .dec   (dec[g]),
            .cnt   (cnt[g]),
            .err_c (cnt_err[g])
        );
    end

    sb_counter #(.CNT_W(CNT_W)) u_icc_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (icc_inc),
        .dec   (icc_dec),
        .cnt   (icc_cnt),
        .err_c (icc_err)
    );

    sb_counter #(.CNT_W(CNT_W)) u_y_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (y_inc),
        .dec   (y_dec),
        .cnt   (y_cnt),
        .err_c (y_err)
    );

    // A last outstanding writer retiring this cycle no longer blocks when bypass is on.
    always_comb begin
        haz          = '0;
        at_max       = '0;
        pending_mask = '0;
        for (int unsigned n = 1; n < NUM_REGS; n++) begin
            pending_mask[n] = cnt[n] != '0;
            at_max[n]       = cnt[n] == {CNT_W{1'b1}};
            haz[n]          = pending_mask[n] &&
                              !(RETIRE_BYPASS && (cnt[n] == CNT_W'(1)) && dec[n]);
        end
        icc_pending = icc_cnt != '0;
        y_pending   = y_cnt != '0;
        icc_haz     = icc_pending && !(RETIRE_BYPASS && (icc_cnt == CNT_W'(1)) && icc_dec);
        y_haz       = y_pending && !(RETIRE_BYPASS && (y_cnt == CNT_W'(1)) && y_dec);

        struct_stall = (issue_wr && at_max[issue_rd]) ||
                       (issue_wr_double && at_max[ADDR_W'(iss_rd1)]) ||
                       (issue_icc && (icc_cnt == {CNT_W{1'b1}})) ||
                       (issue_y && (y_cnt == {CNT_W{1'b1}}));

        stall = (chk_rs1_en && (chk_rs1 != '0) && haz[chk_rs1]) ||
                (chk_rs2_en && (chk_rs2 != '0) && haz[chk_rs2]) ||
                (chk_rs3_en && haz[chk_rs3]) ||
                (chk_rs3_double && haz[ADDR_W'(rd_next(RD_W'(chk_rs3), NUM_REGS))]) ||
                (chk_icc && icc_haz) ||
                (chk_y && y_haz) ||
                struct_stall;
    end

    // Sticky protocol error; a flush cycle neither sets nor clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (!flush && (odd_err || (|cnt_err) || icc_err || y_err)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: bypass and non-bypass instances share stimulus,
// expected outputs flow through a queue from drive time to sample time.
module tb_id_hazard_scoreboard;
    import id_hazard_scoreboard_pkg::*;

    typedef struct packed {
        logic [4:0] rs1;
        logic       rs1_en;
        logic [4:0] rs2;
        logic       rs2_en;
        logic [4:0] rs3;
        logic       rs3_en;
        logic       rs3_d;
        logic       icc;
        logic       y;
    } chk_t;

    typedef struct packed {
        logic        stall_b;
        logic        stall_n;
        logic [31:0] mask;
        logic        icc;
        logic        y;
        logic        err;
    } exp_t;

    typedef struct {
        string    name;
        logic     rst;
        chk_t     c;
        res_upd_t iss;
        res_upd_t ret;
        logic     fl;
        exp_t     e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  chk_rs1, chk_rs2, chk_rs3;
    logic        chk_rs1_en, chk_rs2_en, chk_rs3_en, chk_rs3_double, chk_icc, chk_y;
    logic        issue_valid, issue_wr, issue_wr_double, issue_icc, issue_y;
    logic [4:0]  issue_rd;
    logic        retire_valid, retire_wr, retire_wr_double, retire_icc, retire_y;
    logic [4:0]  retire_rd;
    logic        flush;
    logic        stall_b, stall_n, icc_b, icc_n, y_b, y_n, err_b, err_n;
    logic [31:0] mask_b, mask_n;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    string name_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.RETIRE_BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .chk_rs1(chk_rs1), .chk_rs1_en(chk_rs1_en), .chk_rs2(chk_rs2), .chk_rs2_en(chk_rs2_en),
        .chk_rs3(chk_rs3), .chk_rs3_en(chk_rs3_en), .chk_rs3_double(chk_rs3_double),
        .chk_icc(chk_icc), .chk_y(chk_y),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .issue_wr_double(issue_wr_double), .issue_icc(issue_icc), .issue_y(issue_y),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_wr(retire_wr),
        .retire_wr_double(retire_wr_double), .retire_icc(retire_icc), .retire_y(retire_y),
        .flush(flush), .stall(stall_b), .pending_mask(mask_b),
        .icc_pending(icc_b), .y_pending(y_b), .err(err_b)
    );

    id_hazard_scoreboard #(.RETIRE_BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset),
        .chk_rs1(chk_rs1), .chk_rs1_en(chk_rs1_en), .chk_rs2(chk_rs2), .chk_rs2_en(chk_rs2_en),
        .chk_rs3(chk_rs3), .chk_rs3_en(chk_rs3_en), .chk_rs3_double(chk_rs3_double),
        .chk_icc(chk_icc), .chk_y(chk_y),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .issue_wr_double(issue_wr_double), .issue_icc(issue_icc), .issue_y(issue_y),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_wr(retire_wr),
        .retire_wr_double(retire_wr_double), .retire_icc(retire_icc), .retire_y(retire_y),
        .flush(flush), .stall(stall_n), .pending_mask(mask_n),
        .icc_pending(icc_n), .y_pending(y_n), .err(err_n)
    );

    function automatic chk_t chk(input int rs1, input logic e1, input int rs2, input logic e2,
                                 input int rs3, input logic e3, input logic d3,
                                 input logic ic, input logic yy);
        chk_t c;
        c.rs1 = 5'(rs1); c.rs1_en = e1; c.rs2 = 5'(rs2); c.rs2_en = e2;
        c.rs3 = 5'(rs3); c.rs3_en = e3; c.rs3_d = d3; c.icc = ic; c.y = yy;
        return c;
    endfunction

    function automatic chk_t c1(input int rs1);
        return chk(rs1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic res_upd_t upd(input logic v, input int rd, input logic wr,
                                     input logic wd, input logic ic, input logic yy);
        res_upd_t u;
        u.valid = v; u.rd = RD_W'(rd); u.wr = wr; u.wr_double = wd; u.icc = ic; u.y = yy;
        return u;
    endfunction

    function automatic res_upd_t wr1(input int rd);
        return upd(1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic exp_t ex(input logic sb, input logic sn, input logic [31:0] m,
                                input logic ic, input logic yy, input logic er);
        exp_t e;
        e.stall_b = sb; e.stall_n = sn; e.mask = m; e.icc = ic; e.y = yy; e.err = er;
        return e;
    endfunction

    function automatic vec_t mk(input string nm, input logic rst, input chk_t c,
                                input res_upd_t i, input res_upd_t r, input logic fl,
                                input exp_t e);
        vec_t v;
        v.name = nm; v.rst = rst; v.c = c; v.iss = i; v.ret = r; v.fl = fl; v.e = e;
        return v;
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        reset            = v.rst;
        chk_rs1          = v.c.rs1;  chk_rs1_en = v.c.rs1_en;
        chk_rs2          = v.c.rs2;  chk_rs2_en = v.c.rs2_en;
        chk_rs3          = v.c.rs3;  chk_rs3_en = v.c.rs3_en;
        chk_rs3_double   = v.c.rs3_d;
        chk_icc          = v.c.icc;  chk_y      = v.c.y;
        issue_valid      = v.iss.valid;  issue_rd  = 5'(v.iss.rd);
        issue_wr         = v.iss.wr;     issue_wr_double = v.iss.wr_double;
        issue_icc        = v.iss.icc;    issue_y   = v.iss.y;
        retire_valid     = v.ret.valid;  retire_rd = 5'(v.ret.rd);
        retire_wr        = v.ret.wr;     retire_wr_double = v.ret.wr_double;
        retire_icc       = v.ret.icc;    retire_y  = v.ret.y;
        flush            = v.fl;
    endtask

    task automatic check_out();
        exp_t  e;
        string nm;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        cmp(nm, "stall_bypass",   32'(stall_b), 32'(e.stall_b));
        cmp(nm, "stall_nobypass", 32'(stall_n), 32'(e.stall_n));
        cmp(nm, "mask_bypass",    mask_b,       e.mask);
        cmp(nm, "mask_nobypass",  mask_n,       e.mask);
        cmp(nm, "icc_bypass",     32'(icc_b),   32'(e.icc));
        cmp(nm, "icc_nobypass",   32'(icc_n),   32'(e.icc));
        cmp(nm, "y_bypass",       32'(y_b),     32'(e.y));
        cmp(nm, "y_nobypass",     32'(y_n),     32'(e.y));
        cmp(nm, "err_bypass",     32'(err_b),   32'(e.err));
        cmp(nm, "err_nobypass",   32'(err_n),   32'(e.err));
    endtask

    // Inputs change on the falling edge; outputs are sampled just after, before the next rise.
    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        exp_q.push_back(v.e);
        name_q.push_back(v.name);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_t        nc;
        res_upd_t    nu;
        logic [31:0] mask_m;

        nc = chk(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        nu = upd(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(mk("init", 1'b1, nc, nu, nu, 1'b0, ex(0, 0, 0, 0, 0, 0)));
        repeat (2) @(posedge clk);

        // Single register producer, bypass vs. no bypass.
        vecs.push_back(mk("reset",    0, nc,     nu,      nu,      0, ex(0, 0, 32'h0,   0, 0, 0)));
        vecs.push_back(mk("iss5",     0, nc,     wr1(5),  nu,      0, ex(0, 0, 32'h0,   0, 0, 0)));
        vecs.push_back(mk("chk5",     0, c1(5),  nu,      nu,      0, ex(1, 1, 32'h20,  0, 0, 0)));
        vecs.push_back(mk("ret5",     0, c1(5),  nu,      wr1(5),  0, ex(0, 1, 32'h20,  0, 0, 0)));
        vecs.push_back(mk("post5",    0, c1(5),  nu,      nu,      0, ex(0, 0, 32'h0,   0, 0, 0)));
        // Double-word producers and the odd-rd protocol error.
        vecs.push_back(mk("ldd8",     0, nc, upd(1, 8, 1, 1, 0, 0), nu, 0, ex(0, 0, 32'h0, 0, 0, 0)));
        vecs.push_back(mk("rs3_6",    0, chk(0, 0, 0, 0, 6, 1, 0, 0, 0), nu, nu, 0, ex(0, 0, 32'h300, 0, 0, 0)));
        vecs.push_back(mk("rs2_9",    0, chk(0, 0, 9, 1, 0, 0, 0, 0, 0), nu, nu, 0, ex(1, 1, 32'h300, 0, 0, 0)));
        vecs.push_back(mk("rs3d_8",   0, chk(0, 0, 0, 0, 8, 0, 1, 0, 0), nu, nu, 0, ex(1, 1, 32'h300, 0, 0, 0)));
        vecs.push_back(mk("ldd9_odd", 0, nc, upd(1, 9, 1, 1, 0, 0), nu, 0, ex(0, 0, 32'h300, 0, 0, 0)));
        vecs.push_back(mk("err_odd",  0, nc, nu, nu, 0, ex(0, 0, 32'h700, 0, 0, 1)));
        vecs.push_back(mk("ret_ldd8", 0, c1(8), nu, upd(1, 8, 1, 1, 0, 0), 0, ex(0, 1, 32'h700, 0, 0, 1)));
        vecs.push_back(mk("rst_mid",  1, chk(0, 0, 9, 1, 0, 0, 0, 0, 0), nu, nu, 0, ex(1, 1, 32'h600, 0, 0, 1)));
        vecs.push_back(mk("post_rst", 0, chk(0, 0, 9, 1, 0, 0, 0, 0, 0), nu, nu, 0, ex(0, 0, 32'h0, 0, 0, 0)));
        // Counter saturation and structural stall.
        vecs.push_back(mk("iss3_a",   0, nc, wr1(3), nu, 0, ex(0, 0, 32'h0, 0, 0, 0)));
        vecs.push_back(mk("iss3_b",   0, nc, wr1(3), nu, 0, ex(0, 0, 32'h8, 0, 0, 0)));
        vecs.push_back(mk("iss3_c",   0, nc, wr1(3), nu, 0, ex(0, 0, 32'h8, 0, 0, 0)));
        vecs.push_back(mk("struct3",  0, nc, upd(0, 3, 1, 0, 0, 0), nu, 0, ex(1, 1, 32'h8, 0, 0, 0)));
        vecs.push_back(mk("force3",   0, nc, wr1(3), nu, 0, ex(1, 1, 32'h8, 0, 0, 0)));
        vecs.push_back(mk("sat_ret_a", 0, nc,    nu, wr1(3), 0, ex(0, 0, 32'h8, 0, 0, 1)));
        vecs.push_back(mk("sat_ret_b", 0, nc,    nu, wr1(3), 0, ex(0, 0, 32'h8, 0, 0, 1)));
        vecs.push_back(mk("sat_ret_c", 0, c1(3), nu, wr1(3), 0, ex(0, 1, 32'h8, 0, 0, 1)));
        vecs.push_back(mk("sat_clear", 0, c1(3), nu, nu,     0, ex(0, 0, 32'h0, 0, 0, 1)));
        // Same-cycle issue and retire of one register.
        vecs.push_back(mk("iss4",     0, nc,    wr1(4), nu,     0, ex(0, 0, 32'h0,  0, 0, 1)));
        vecs.push_back(mk("iss_ret4", 0, c1(4), wr1(4), wr1(4), 0, ex(0, 1, 32'h10, 0, 0, 1)));
        vecs.push_back(mk("hold4",    0, c1(4), nu,     nu,     0, ex(1, 1, 32'h10, 0, 0, 1)));
        vecs.push_back(mk("ret4",     0, nc,    nu,     wr1(4), 0, ex(0, 0, 32'h10, 0, 0, 1)));
        // icc producer/consumer and r0.
        vecs.push_back(mk("subcc",    0, nc, upd(1, 0, 0, 0, 1, 0), nu, 0, ex(0, 0, 32'h0, 0, 0, 1)));
        vecs.push_back(mk("bicc",     0, chk(0, 0, 0, 0, 0, 0, 0, 1, 0), nu, nu, 0, ex(1, 1, 32'h0, 1, 0, 1)));
        vecs.push_back(mk("bicc_ret", 0, chk(0, 0, 0, 0, 0, 0, 0, 1, 0), nu, upd(1, 0, 0, 0, 1, 0), 0,
                          ex(0, 1, 32'h0, 1, 0, 1)));
        vecs.push_back(mk("bicc_go",  0, chk(0, 0, 0, 0, 0, 0, 0, 1, 0), nu, nu, 0, ex(0, 0, 32'h0, 0, 0, 1)));
        vecs.push_back(mk("iss_r0",   0, c1(0), wr1(0), nu, 0, ex(0, 0, 32'h0, 0, 0, 1)));
        vecs.push_back(mk("chk_r0",   0, chk(0, 1, 0, 1, 0, 1, 0, 0, 0), nu, nu, 0, ex(0, 0, 32'h0, 0, 0, 1)));
        // Flush against pending regs, icc and Y plus a simultaneous issue.
        vecs.push_back(mk("p1",       0, nc, upd(1, 1, 1, 0, 1, 1), nu, 0, ex(0, 0, 32'h0, 0, 0, 1)));
        vecs.push_back(mk("p2",       0, nc, wr1(2), nu, 0, ex(0, 0, 32'h2, 1, 1, 1)));
        vecs.push_back(mk("rs2_off",  0, chk(0, 0, 2, 0, 0, 0, 0, 0, 0), nu, nu, 0, ex(0, 0, 32'h6, 1, 1, 1)));
        vecs.push_back(mk("y_chk",    0, chk(0, 0, 0, 0, 0, 0, 0, 0, 1), nu, nu, 0, ex(1, 1, 32'h6, 1, 1, 1)));
        vecs.push_back(mk("flush",    0, nc,    wr1(7), nu, 1, ex(0, 0, 32'h6, 1, 1, 1)));
        vecs.push_back(mk("post_fl",  0, c1(7), nu,     nu, 0, ex(0, 0, 32'h0, 0, 0, 1)));
        // Underflow after a clean reset.
        vecs.push_back(mk("rst2",     1, nc, nu, nu,     0, ex(0, 0, 32'h0, 0, 0, 1)));
        vecs.push_back(mk("unf",      0, nc, nu, wr1(6), 0, ex(0, 0, 32'h0, 0, 0, 0)));
        vecs.push_back(mk("unf_err",  0, nc, nu, nu,     0, ex(0, 0, 32'h0, 0, 0, 1)));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Fill every register one per cycle, tracking the expected mask.
        apply(mk("rst3", 1, nc, nu, nu, 0, ex(0, 0, 32'h0, 0, 0, 1)));
        mask_m = '0;
        for (int n = 1; n < 32; n++) begin
            apply(mk($sformatf("fill%0d", n), 0, nc, wr1(n), nu, 0, ex(0, 0, mask_m, 0, 0, 0)));
            mask_m[n] = 1'b1;
        end
        apply(mk("fill_full",  0, c1(31), nu, nu, 0, ex(1, 1, 32'hFFFF_FFFE, 0, 0, 0)));
        apply(mk("fill_flush", 0, nc,     nu, nu, 1, ex(0, 0, 32'hFFFF_FFFE, 0, 0, 0)));
        // Pair at the top of the file, and rs3+1 wrapping onto r0.
        apply(mk("ldd30",   0, nc, upd(1, 30, 1, 1, 0, 0), nu, 0, ex(0, 0, 32'h0, 0, 0, 0)));
        apply(mk("rs3d_30", 0, chk(0, 0, 0, 0, 30, 0, 1, 0, 0), nu, nu, 0,
                 ex(1, 1, 32'hC000_0000, 0, 0, 0)));
        apply(mk("rs3d_31", 0, chk(0, 0, 0, 0, 31, 0, 1, 0, 0), nu, nu, 0,
                 ex(0, 0, 32'hC000_0000, 0, 0, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
